// File: rtl/fetch_stage.sv
// Instruction fetch stage. Owns the PC, issues word reads to instruction
// memory over a req/ack handshake, presents one instruction at a time to
// decode (honouring its stall) and redirects on execute flushes.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] BOOT_PC    = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Control state
  state_t      r_state;
  logic        r_req;
  // r_pc is the address currently (or next) requested. In DRAIN it keeps
  // the pre-flush address so the outstanding request stays stable.
  logic [31:0] r_pc;
  // Redirect target remembered while the old request drains.
  logic [31:0] r_target;

  // Output registers seen by decode
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_valid;

  // One-entry skid buffer: catches a word acked while decode is stalled
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_skid_valid;

  // Combinational helpers
  logic        w_ack;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_flush_target;
  logic        w_out_free;
  logic        w_out_consumed;

  // An ack only counts while a request is actually outstanding.
  assign w_ack          = imem_ack_in & r_req;
  // Wraps modulo 2^32 naturally through the 32-bit add.
  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_flush_target = flush_pc_in & 32'hFFFF_FFFC;
  // Output regs may be overwritten when empty or being taken this cycle.
  assign w_out_free     = !r_valid || !stall_in;
  assign w_out_consumed = r_valid && !stall_in;

  assign imem_req_out  = r_req;
  assign imem_addr_out = r_pc;
  assign instr_out     = r_instr;
  assign pc_out        = r_pc_out;
  assign valid_out     = r_valid;

  // Fetch FSM: PC, request, output and skid registers all advance together
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_req        <= 1'b0;
      r_pc         <= BOOT_PC;
      r_target     <= BOOT_PC;
      r_instr      <= NOP_INSTR;
      r_pc_out     <= BOOT_PC;
      r_valid      <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= BOOT_PC;
      r_skid_valid <= 1'b0;
    end else if (flush_in) begin
      // Redirect wins over stall and ack: nothing older may reach decode.
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_req <= 1'b1;
          if (w_ack) begin
            // Request just completed; drop its data and go to the target.
            r_pc    <= w_flush_target;
            r_state <= S_FETCH;
          end else begin
            // Request still open; it must finish at its original address.
            r_target <= w_flush_target;
            r_state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_req <= 1'b1;
          if (w_ack) begin
            r_pc    <= w_flush_target;
            r_state <= S_FETCH;
          end else begin
            r_target <= w_flush_target;
            r_state  <= S_DRAIN;
          end
        end
        default: begin
          // IDLE / HOLD have nothing outstanding at the memory.
          r_req   <= 1'b1;
          r_pc    <= w_flush_target;
          r_state <= S_FETCH;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req   <= 1'b1;
          r_state <= S_FETCH;
        end

        S_FETCH: begin
          if (w_ack) begin
            r_pc <= w_pc_plus4;
            if (w_out_free) begin
              // Straight through to decode: one instruction per cycle.
              r_instr  <= imem_data_in;
              r_pc_out <= r_pc;
              r_valid  <= 1'b1;
              r_req    <= 1'b1;
              r_state  <= S_FETCH;
            end else begin
              // Decode is holding its current word; park the new one.
              r_skid_instr <= imem_data_in;
              r_skid_pc    <= r_pc;
              r_skid_valid <= 1'b1;
              r_req        <= 1'b0;
              r_state      <= S_HOLD;
            end
          end else if (w_out_consumed) begin
            r_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (!stall_in) begin
            r_instr      <= r_skid_instr;
            r_pc_out     <= r_skid_pc;
            r_valid      <= r_skid_valid;
            r_skid_valid <= 1'b0;
            r_req        <= 1'b1;
            r_state      <= S_FETCH;
          end
        end

        S_DRAIN: begin
          // Output is already empty after the flush; just retire the
          // stale request and restart at the remembered target.
          if (w_ack) begin
            r_pc    <= r_target;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end

        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
